// File: rtl/gate_test_sequencer_pkg.sv
// Shared types and limits for the gate test sequencer.
// State encodings and legal parameter ranges.
package gate_test_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int N_IN_MIN   = 1;
  localparam int N_IN_MAX   = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int SETTLE_W   = 4;

endpackage

// File: rtl/gts_vec_counter.sv
// Vector and settle counters for the gate test sequencer.
// Settle counter saturates at SETTLE-1 so it is idle-safe.
module gts_vec_counter
  import gate_test_sequencer_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            advance,
  output logic [N_IN-1:0] vec,
  output logic            settle_done,
  output logic            last_vec
);

  localparam logic [SETTLE_W-1:0] CNT_LAST =
    SETTLE_W'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST =
    {N_IN{1'b1}};

  logic [N_IN-1:0]     vec_q;
  logic [N_IN-1:0]     vec_d;
  logic [SETTLE_W-1:0] cnt_q;
  logic [SETTLE_W-1:0] cnt_d;

  // Next vector / settle count.
  always_comb begin
    vec_d = vec_q;
    cnt_d = cnt_q;
    if (clear) begin
      vec_d = '0;
      cnt_d = '0;
    end else if (advance) begin
      vec_d = vec_q + 1'b1;
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else begin
      vec_q <= vec_d;
      cnt_q <= cnt_d;
    end
  end

  assign vec         = vec_q;
  assign settle_done = (cnt_q == CNT_LAST);
  assign last_vec    = (vec_q == VEC_LAST);

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive sequencer/checker for an N-input gate.
// Walks all vectors, samples after settle, logs errors.
module gate_test_sequencer
  import gate_test_sequencer_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2**N_IN-1:0] truth_tbl,
  output logic [N_IN-1:0]    gate_in,
  input  logic               gate_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [N_IN:0]      err_cnt,
  output logic               first_err_valid,
  output logic [N_IN-1:0]    first_err_vec
);

  state_e state_q, state_d;

  logic [2**N_IN-1:0] tbl_q, tbl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [N_IN:0]      err_q, err_d;
  logic               fev_q, fev_d;
  logic [N_IN-1:0]    fvec_q, fvec_d;

  logic            clear;
  logic            advance;
  logic [N_IN-1:0] vec;
  logic            settle_done;
  logic            last_vec;

  gts_vec_counter #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .advance     (advance),
    .vec         (vec),
    .settle_done (settle_done),
    .last_vec    (last_vec)
  );

  // Next state and result bookkeeping.
  always_comb begin
    state_d = state_q;
    tbl_d   = tbl_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fvec_d  = fvec_q;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          tbl_d   = truth_tbl;
          err_d   = '0;
          fev_d   = 1'b0;
          fvec_d  = '0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          clear   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (settle_done) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // X on gate_out falls into the mismatch branch.
        if (gate_out == tbl_q[vec]) begin
          err_d = err_q;
        end else begin
          err_d = err_q + 1'b1;
          if (!fev_q) begin
            fev_d  = 1'b1;
            fvec_d = vec;
          end
        end
        if (last_vec) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          advance = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        clear   = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tbl_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fvec_q  <= '0;
    end else begin
      state_q <= state_d;
      tbl_q   <= tbl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fvec_q  <= fvec_d;
    end
  end

  assign gate_in         = vec;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_valid = fev_q;
  assign first_err_vec   = fvec_q;

endmodule
